// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / hazard bus between the pipeline control and fwd_hazard_unit.
// The master drives the pipeline state; the slave returns forwarding selects, stall and scoreboard.
interface fwd_hazard_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned N_STAGE = 2,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned SEL_W = $clog2(N_STAGE + 1);
  localparam int unsigned N_REG = 1 << REG_AW;

  // execute-side forwarding
  logic [N_SRC*REG_AW-1:0]   ex_src_idx;
  logic [N_SRC-1:0]          ex_src_valid;
  logic [N_STAGE*REG_AW-1:0] stg_rd;
  logic [N_STAGE-1:0]        stg_reg_write;
  logic [N_SRC*SEL_W-1:0]    fwd_sel;

  // decode-side hazard detection
  logic [N_SRC*REG_AW-1:0]   id_src_idx;
  logic [N_SRC-1:0]          id_src_valid;
  logic [REG_AW-1:0]         id_rd;
  logic                      id_rd_valid;
  logic                      ex_is_load;
  logic [REG_AW-1:0]         ex_rd;

  // multi-cycle scoreboard
  logic                      mc_issue;
  logic [REG_AW-1:0]         mc_issue_rd;
  logic                      mc_done;
  logic [REG_AW-1:0]         mc_done_rd;

  logic                      stall;
  logic [N_REG-1:0]          sb_pending;
  logic [CNT_W-1:0]          stall_cnt;
  logic                      stall_cnt_clr;

  modport master (
    output ex_src_idx, ex_src_valid, stg_rd, stg_reg_write,
    output id_src_idx, id_src_valid, id_rd, id_rd_valid, ex_is_load, ex_rd,
    output mc_issue, mc_issue_rd, mc_done, mc_done_rd, stall_cnt_clr,
    input  fwd_sel, stall, sb_pending, stall_cnt
  );

  modport slave (
    input  ex_src_idx, ex_src_valid, stg_rd, stg_reg_write,
    input  id_src_idx, id_src_valid, id_rd, id_rd_valid, ex_is_load, ex_rd,
    input  mc_issue, mc_issue_rd, mc_done, mc_done_rd, stall_cnt_clr,
    output fwd_sel, stall, sb_pending, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Generalised operand forwarding, load-use stall detection and multi-cycle writeback scoreboard.
// Only the scoreboard bitmap and the stall counter are state; forwarding and stall are combinational.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned N_STAGE = 2,
  parameter int unsigned CNT_W   = 32
) (
  input logic         clk,
  input logic         reset_n,
  fwd_hazard_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_STAGE + 1);
  localparam int unsigned N_REG = 1 << REG_AW;

  logic [N_SRC*SEL_W-1:0] fwd_sel_c;
  logic [N_REG-1:0]       sb_hit_c;
  logic                   lu_c;
  logic                   sb_c;
  logic                   stall_c;
  logic [N_REG-1:0]       sb_pending_q;
  logic [N_REG-1:0]       sb_pending_d;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic [CNT_W-1:0]       stall_cnt_d;

  // Per-channel forwarding select; scanning from the oldest stage down lets the nearest match win.
  always_comb begin
    fwd_sel_c = '0;
    for (int c = 0; c < N_SRC; c++) begin
      logic [REG_AW-1:0] idx;
      logic [SEL_W-1:0]  sel;
      idx = bus.ex_src_idx[c*REG_AW +: REG_AW];
      sel = '0;
      if (bus.ex_src_valid[c] && (idx != '0)) begin
        for (int k = N_STAGE - 1; k >= 0; k--) begin
          if (bus.stg_reg_write[k] && (bus.stg_rd[k*REG_AW +: REG_AW] == idx)) begin
            sel = SEL_W'(k + 1);
          end
        end
      end
      fwd_sel_c[c*SEL_W +: SEL_W] = sel;
    end
  end

  // A same-cycle writeback releases the register (write-through); a same-cycle issue blocks it.
  always_comb begin
    sb_hit_c = '0;
    for (int r = 1; r < N_REG; r++) begin
      sb_hit_c[r] = (sb_pending_q[r] && !(bus.mc_done && (bus.mc_done_rd == REG_AW'(r)))) ||
                    (bus.mc_issue && (bus.mc_issue_rd == REG_AW'(r)));
    end
  end

  // Load-use and scoreboard (RAW on sources, WAW on rd) hazard detection.
  always_comb begin
    lu_c = 1'b0;
    sb_c = 1'b0;
    for (int c = 0; c < N_SRC; c++) begin
      logic [REG_AW-1:0] idx;
      idx = bus.id_src_idx[c*REG_AW +: REG_AW];
      if (bus.id_src_valid[c]) begin
        if (bus.ex_is_load && (bus.ex_rd != '0) && (idx == bus.ex_rd)) begin
          lu_c = 1'b1;
        end
        if (sb_hit_c[idx]) begin
          sb_c = 1'b1;
        end
      end
    end
    if (bus.id_rd_valid && sb_hit_c[bus.id_rd]) begin
      sb_c = 1'b1;
    end
    stall_c = lu_c | sb_c;
  end

  // Scoreboard next state: issue is applied after done so a simultaneous pair leaves the entry set.
  always_comb begin
    sb_pending_d = sb_pending_q;
    if (bus.mc_done && (bus.mc_done_rd != '0)) begin
      sb_pending_d[bus.mc_done_rd] = 1'b0;
    end
    if (bus.mc_issue && (bus.mc_issue_rd != '0)) begin
      sb_pending_d[bus.mc_issue_rd] = 1'b1;
    end
    sb_pending_d[0] = 1'b0;
  end

  // Saturating stall-cycle counter with synchronous clear taking priority.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall_cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_pending_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      sb_pending_q <= sb_pending_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.fwd_sel    = fwd_sel_c;
  assign bus.stall      = stall_c;
  assign bus.sb_pending = sb_pending_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule
